// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the staged reset sequencer.
// State encodings, counter widths and the rst_out assertion level.
package reset_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_SOFT      = 3'd4
  } seq_state_e;

  localparam int DELAY_CNT_W = 8;
  localparam int HOLD_CNT_W  = 8;
  localparam int LOSS_CNT_W  = 8;
  localparam int STAGE_IDX_W = 3;
  // One extra bit so the internal stage counter can hold NUM_STAGES == 8.
  localparam int STAGE_CNT_W = STAGE_IDX_W + 1;

  localparam logic RST_ASSERT = 1'b1;

  // Lock counter only needs to reach LOCK_FILTER-1.
  function automatic int lock_cnt_width(input int filter);
    return (filter <= 2) ? 1 : $clog2(filter);
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Both flops clear to 0 under synchronous reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES domain resets in order once PLL lock is filtered stable.
// Soft requests and lock loss re-assert every domain and restart the sequence.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   HOLD       | just out of reset, everything asserted
//   WAIT_LOCK  | all asserted, counting consecutive locked_s cycles
//   RELEASE    | releasing one stage every STAGE_DELAY cycles
//   RUN        | all stages released, seq_done high
//   SOFT       | soft request seen, holding all asserted SOFT_HOLD cycles
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_DELAY = 16,
  parameter int LOCK_FILTER = 8,
  parameter int SOFT_HOLD   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pll_locked,
  input  logic                   soft_req,
  output logic [NUM_STAGES-1:0]  rst_out,
  output logic                   seq_done,
  output logic [STAGE_IDX_W-1:0] stage_idx,
  output logic [LOSS_CNT_W-1:0]  lock_loss_cnt
);

  localparam int LOCK_W = lock_cnt_width(LOCK_FILTER);

  localparam logic [NUM_STAGES-1:0]  RST_ALL    = {NUM_STAGES{RST_ASSERT}};
  localparam logic [LOCK_W-1:0]      LOCK_LAST  = LOCK_W'(LOCK_FILTER - 1);
  localparam logic [DELAY_CNT_W-1:0] DELAY_LAST = DELAY_CNT_W'(STAGE_DELAY - 1);
  localparam logic [HOLD_CNT_W-1:0]  HOLD_LAST  = HOLD_CNT_W'(SOFT_HOLD - 1);
  localparam logic [STAGE_CNT_W-1:0] STAGE_LAST = STAGE_CNT_W'(NUM_STAGES - 1);
  localparam logic [LOSS_CNT_W-1:0]  LOSS_MAX   = '1;

  logic locked_s;

  seq_state_e                state_q, state_d;
  logic [LOCK_W-1:0]         lock_cnt_q, lock_cnt_d;
  logic [DELAY_CNT_W-1:0]    delay_cnt_q, delay_cnt_d;
  logic [HOLD_CNT_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [STAGE_CNT_W-1:0]    stage_q, stage_d;
  logic [NUM_STAGES-1:0]     rst_out_q, rst_out_d;
  logic                      seq_done_q, seq_done_d;
  logic [LOSS_CNT_W-1:0]     loss_cnt_q, loss_cnt_d;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_locked),
    .q     (locked_s)
  );

  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    delay_cnt_d = delay_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    stage_d     = stage_q;
    rst_out_d   = rst_out_q;
    seq_done_d  = seq_done_q;
    loss_cnt_d  = loss_cnt_q;

    unique case (state_q)
      ST_HOLD: begin
        rst_out_d  = RST_ALL;
        seq_done_d = 1'b0;
        lock_cnt_d = '0;
        state_d    = ST_WAIT_LOCK;
      end

      ST_WAIT_LOCK: begin
        rst_out_d  = RST_ALL;
        seq_done_d = 1'b0;
        if (!locked_s) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LOCK_LAST) begin
          lock_cnt_d  = '0;
          delay_cnt_d = '0;
          stage_d     = '0;
          state_d     = ST_RELEASE;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end

      ST_RELEASE, ST_RUN: begin
        // Lock loss wins over a simultaneous soft request.
        if (!locked_s) begin
          rst_out_d  = RST_ALL;
          seq_done_d = 1'b0;
          stage_d    = '0;
          lock_cnt_d = '0;
          state_d    = ST_WAIT_LOCK;
          if (loss_cnt_q != LOSS_MAX) begin
            loss_cnt_d = loss_cnt_q + 1'b1;
          end
        end else if (soft_req) begin
          rst_out_d  = RST_ALL;
          seq_done_d = 1'b0;
          stage_d    = '0;
          hold_cnt_d = '0;
          state_d    = ST_SOFT;
        end else if (state_q == ST_RELEASE) begin
          if (delay_cnt_q == DELAY_LAST) begin
            delay_cnt_d = '0;
            stage_d     = stage_q + 1'b1;
            for (int i = 0; i < NUM_STAGES; i++) begin
              if (STAGE_CNT_W'(i) == stage_q) begin
                rst_out_d[i] = ~RST_ASSERT;
              end
            end
            if (stage_q == STAGE_LAST) begin
              seq_done_d = 1'b1;
              state_d    = ST_RUN;
            end
          end else begin
            delay_cnt_d = delay_cnt_q + 1'b1;
          end
        end
      end

      ST_SOFT: begin
        rst_out_d  = RST_ALL;
        seq_done_d = 1'b0;
        if (hold_cnt_q == HOLD_LAST) begin
          lock_cnt_d = '0;
          state_d    = ST_WAIT_LOCK;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      default: begin
        rst_out_d  = RST_ALL;
        seq_done_d = 1'b0;
        stage_d    = '0;
        state_d    = ST_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_HOLD;
      lock_cnt_q  <= '0;
      delay_cnt_q <= '0;
      hold_cnt_q  <= '0;
      stage_q     <= '0;
      rst_out_q   <= RST_ALL;
      seq_done_q  <= 1'b0;
      loss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      delay_cnt_q <= delay_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      stage_q     <= stage_d;
      rst_out_q   <= rst_out_d;
      seq_done_q  <= seq_done_d;
      loss_cnt_q  <= loss_cnt_d;
    end
  end

  // With NUM_STAGES == 8 the completed index wraps to 0 on the 3-bit port.
  assign rst_out       = rst_out_q;
  assign seq_done      = seq_done_q;
  assign stage_idx     = stage_q[STAGE_IDX_W-1:0];
  assign lock_loss_cnt = loss_cnt_q;

endmodule
